// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/sequencing controller for the FD/DE/EM/MW latches.
// Decides per cycle whether each latch loads, holds or takes a bubble,
// drains the pipe on halt and keeps saturating stall/flush debug counters.
module pipeline_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic [4:0]       fd_rs,
   input  logic [4:0]       fd_rt,
   input  logic             fd_uses_rt,
   input  logic             de_dcuREN,
   input  logic [4:0]       de_rt,
   input  logic             de_halt,
   input  logic             em_mem_req,
   input  logic             em_taken,
   input  logic             mw_halt,
   output logic             pc_en,
   output logic             fd_en,
   output logic             de_en,
   output logic             em_en,
   output logic             mw_en,
   output logic             fd_flush,
   output logic             de_flush,
   output logic             em_flush,
   output logic             mw_flush,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             dmem_wait, load_use;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // A load in DE whose nonzero destination feeds the instruction in FD
   assign dmem_wait = em_mem_req & ~dhit;
   assign load_use  = de_dcuREN & (de_rt != 5'd0) &
                      ((de_rt == fd_rs) | (fd_uses_rt & (de_rt == fd_rt)));

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

   // Latch/PC controls: priority-resolved hazards, reset forces bubbles everywhere
   always_comb begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      de_en    = 1'b0;
      em_en    = 1'b0;
      mw_en    = 1'b0;
      fd_flush = 1'b0;
      de_flush = 1'b0;
      em_flush = 1'b0;
      mw_flush = 1'b0;
      halted   = 1'b0;
      if (RST) begin
         fd_flush = 1'b1;
         de_flush = 1'b1;
         em_flush = 1'b1;
         mw_flush = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               if (dmem_wait) begin
                  // Memory op stuck in EM: everything upstream holds, MW gets a bubble
                  mw_flush = 1'b1;
               end else if (em_taken) begin
                  // Redirect squashes the three younger stages, even a pending fetch
                  pc_en    = 1'b1;
                  fd_flush = 1'b1;
                  de_flush = 1'b1;
                  em_flush = 1'b1;
                  mw_en    = 1'b1;
               end else if (load_use) begin
                  de_flush = 1'b1;
                  em_en    = 1'b1;
                  mw_en    = 1'b1;
               end else if (!ihit) begin
                  fd_flush = 1'b1;
                  de_en    = 1'b1;
                  em_en    = 1'b1;
                  mw_en    = 1'b1;
               end else begin
                  pc_en = 1'b1;
                  fd_en = 1'b1;
                  de_en = 1'b1;
                  em_en = 1'b1;
                  mw_en = 1'b1;
               end
            end
            DRAIN: begin
               // Only the instructions older than the halt keep moving
               if (dmem_wait) begin
                  mw_flush = 1'b1;
               end else begin
                  fd_flush = 1'b1;
                  de_flush = 1'b1;
                  em_en    = 1'b1;
                  mw_en    = 1'b1;
               end
            end
            HALTED: halted = 1'b1;
            default: ;
         endcase
      end
   end

   // Next state and saturating counters; counters only move while in RUN
   always_comb begin
      state_d     = state_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      case (state_q)
         RUN: begin
            if (de_halt & ~dmem_wait & ~em_taken) state_d = DRAIN;
            if (!pc_en && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_ONE;
            if (!dmem_wait && em_taken && flush_cnt_q != '1)
               flush_cnt_d = flush_cnt_q + CNT_ONE;
         end
         DRAIN:   if (mw_halt) state_d = HALTED;
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   // State and counter registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= RUN;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: hand-derived vector table, a load-use saturation
// sequence on a 4-bit-counter instance, and random stimulus vs a spec model.
module tb_pipeline_ctrl;

   typedef struct packed {
      logic       rst, ihit, dhit;
      logic [4:0] rs, rt;
      logic       urt, ren;
      logic [4:0] drt;
      logic       dh, req, tk, mh;
   } vin_t;

   typedef struct {
      vin_t       in;
      logic [9:0] o;
      int         st;
      int         fl;
   } vec_t;

   // Output vector order: {pc, fd_en, de_en, em_en, mw_en, fd_fl, de_fl, em_fl, mw_fl, halted}
   localparam logic [9:0] O_RST = 10'b0_0000_1111_0;
   localparam logic [9:0] O_P1  = 10'b0_0000_0001_0;
   localparam logic [9:0] O_P2  = 10'b1_0001_1110_0;
   localparam logic [9:0] O_P3  = 10'b0_0011_0100_0;
   localparam logic [9:0] O_P4  = 10'b0_0111_1000_0;
   localparam logic [9:0] O_P5  = 10'b1_1111_0000_0;
   localparam logic [9:0] O_DRN = 10'b0_0011_1100_0;
   localparam logic [9:0] O_HLT = 10'b0_0000_0000_1;

   logic CLK = 1'b0;
   logic RST, ihit, dhit, fd_uses_rt, de_dcuREN, de_halt, em_mem_req, em_taken, mw_halt;
   logic [4:0] fd_rs, fd_rt, de_rt;
   logic pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush, mw_flush, halted;
   logic [15:0] stall_cnt, flush_cnt;
   logic pc_en4, fd_en4, de_en4, em_en4, mw_en4, fd_flush4, de_flush4, em_flush4, mw_flush4, halted4;
   logic [3:0] stall_cnt4, flush_cnt4;

   int total = 0;
   int bad   = 0;
   vin_t cur;
   vec_t tbl[$];

   // Reference model state: 0 = run, 1 = drain, 2 = halted
   int m_state = 0, m_st = 0, m_fl = 0, m_st4 = 0;

   always #5 CLK = ~CLK;

   pipeline_ctrl #(.CNT_W(16)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .fd_rs(fd_rs), .fd_rt(fd_rt),
      .fd_uses_rt(fd_uses_rt), .de_dcuREN(de_dcuREN), .de_rt(de_rt), .de_halt(de_halt),
      .em_mem_req(em_mem_req), .em_taken(em_taken), .mw_halt(mw_halt),
      .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en), .mw_en(mw_en),
      .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush), .mw_flush(mw_flush),
      .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

   pipeline_ctrl #(.CNT_W(4)) dut4 (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .fd_rs(fd_rs), .fd_rt(fd_rt),
      .fd_uses_rt(fd_uses_rt), .de_dcuREN(de_dcuREN), .de_rt(de_rt), .de_halt(de_halt),
      .em_mem_req(em_mem_req), .em_taken(em_taken), .mw_halt(mw_halt),
      .pc_en(pc_en4), .fd_en(fd_en4), .de_en(de_en4), .em_en(em_en4), .mw_en(mw_en4),
      .fd_flush(fd_flush4), .de_flush(de_flush4), .em_flush(em_flush4), .mw_flush(mw_flush4),
      .halted(halted4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4));

   function automatic vin_t mkin(logic r, logic ih, logic dh_, logic [4:0] rs, logic [4:0] rt,
                                 logic urt, logic ren, logic [4:0] drt, logic dhl,
                                 logic req, logic tk, logic mh);
      vin_t v;
      v = '{rst:r, ihit:ih, dhit:dh_, rs:rs, rt:rt, urt:urt, ren:ren, drt:drt,
            dh:dhl, req:req, tk:tk, mh:mh};
      return v;
   endfunction

   task automatic add(input vin_t i, input logic [9:0] o, input int st, input int fl);
      vec_t e;
      e.in = i; e.o = o; e.st = st; e.fl = fl;
      tbl.push_back(e);
   endtask

   task automatic apply(input vin_t v);
      cur = v;
      RST = v.rst; ihit = v.ihit; dhit = v.dhit; fd_rs = v.rs; fd_rt = v.rt;
      fd_uses_rt = v.urt; de_dcuREN = v.ren; de_rt = v.drt; de_halt = v.dh;
      em_mem_req = v.req; em_taken = v.tk; mw_halt = v.mh;
   endtask

   function automatic logic [9:0] dut_outs();
      return {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush, mw_flush, halted};
   endfunction

   // Expected controls straight from the hazard priority list
   function automatic logic [9:0] model_outs(input vin_t v, input int st);
      logic p1, lu;
      p1 = v.req && !v.dhit;
      lu = v.ren && v.drt != 0 && (v.drt == v.rs || (v.urt && v.drt == v.rt));
      if (v.rst)   return O_RST;
      if (st == 2) return O_HLT;
      if (st == 1) return p1 ? O_P1 : O_DRN;
      if (p1)      return O_P1;
      if (v.tk)    return O_P2;
      if (lu)      return O_P3;
      if (!v.ihit) return O_P4;
      return O_P5;
   endfunction

   // Advance the model across the coming clock edge
   task automatic model_step();
      logic [9:0] o;
      o = model_outs(cur, m_state);
      if (cur.rst) begin
         m_state = 0; m_st = 0; m_fl = 0; m_st4 = 0;
      end else if (m_state == 0) begin
         if (o[9] == 1'b0) begin
            if (m_st < 65535) m_st++;
            if (m_st4 < 15) m_st4++;
         end
         if (o == O_P2 && m_fl < 65535) m_fl++;
         if (cur.dh && o != O_P1 && o != O_P2) m_state = 1;
      end else if (m_state == 1) begin
         if (cur.mh) m_state = 2;
      end
   endtask

   task automatic chk(input string nm, input logic [9:0] eo, input int est, input int efl);
      total++;
      if (dut_outs() !== eo) begin
         bad++;
         $display("FAIL %s outs: got %b want %b", nm, dut_outs(), eo);
      end
      total++;
      if (stall_cnt !== 16'(est)) begin
         bad++;
         $display("FAIL %s stall_cnt: got %0d want %0d", nm, stall_cnt, est);
      end
      total++;
      if (flush_cnt !== 16'(efl)) begin
         bad++;
         $display("FAIL %s flush_cnt: got %0d want %0d", nm, flush_cnt, efl);
      end
   endtask

   initial begin
      vin_t idle, lu5;
      idle = mkin(0,1,0, 0,0,0, 0,0, 0,0,0,0);
      lu5  = mkin(0,1,0, 5,0,0, 1,5, 0,0,0,0);
      apply(mkin(1,1,0, 0,0,0, 0,0, 0,0,0,0));

      //   rst ih dh  rs rt urt ren drt dh req tk mh
      add(mkin(1,1,0, 0,0,0, 0,0, 0,0,0,0), O_RST, 0, 0);
      add(mkin(1,1,0, 0,0,0, 0,0, 0,0,0,0), O_RST, 0, 0);
      add(idle,                             O_P5,  0, 0);
      add(lu5,                              O_P3,  0, 0);
      add(idle,                             O_P5,  1, 0);
      add(mkin(0,1,0, 0,0,0, 1,0, 0,0,0,0), O_P5,  1, 0);  // de_rt = 0: no hazard
      add(mkin(0,1,0, 3,7,1, 1,7, 0,0,0,0), O_P3,  1, 0);  // match on rt
      add(mkin(0,1,0, 3,7,0, 1,7, 0,0,0,0), O_P5,  2, 0);  // rt not a source
      add(mkin(0,1,0, 0,0,0, 0,0, 0,1,1,0), O_P1,  2, 0);  // dmem wait beats branch
      add(mkin(0,1,0, 0,0,0, 0,0, 0,1,1,0), O_P1,  3, 0);
      add(mkin(0,1,0, 0,0,0, 0,0, 0,1,1,0), O_P1,  4, 0);
      add(mkin(0,1,1, 0,0,0, 0,0, 0,1,1,0), O_P2,  5, 0);  // dhit releases redirect
      add(idle,                             O_P5,  5, 1);
      add(mkin(0,0,0, 0,0,0, 0,0, 0,0,0,0), O_P4,  5, 1);
      add(mkin(0,0,0, 0,0,0, 0,0, 0,0,0,0), O_P4,  6, 1);
      add(mkin(0,0,0, 0,0,0, 0,0, 0,0,1,0), O_P2,  7, 1);  // redirect ignores ihit
      add(idle,                             O_P5,  7, 2);
      add(mkin(0,0,0, 5,0,0, 1,5, 0,0,0,0), O_P3,  7, 2);  // load-use beats fetch wait
      add(mkin(0,1,0, 0,0,0, 0,0, 1,0,0,0), O_P5,  8, 2);  // halt in DE -> drain
      add(idle,                             O_DRN, 8, 2);
      add(mkin(0,1,0, 0,0,0, 0,0, 0,1,0,0), O_P1,  8, 2);  // dmem wait in drain
      add(mkin(0,1,0, 0,0,0, 0,0, 0,0,1,0), O_DRN, 8, 2);  // taken ignored
      add(mkin(0,1,0, 0,0,0, 0,0, 0,0,0,1), O_DRN, 8, 2);  // mw_halt
      add(idle,                             O_HLT, 8, 2);
      add(mkin(0,0,0, 0,0,0, 0,0, 0,0,1,0), O_HLT, 8, 2);
      add(mkin(1,1,0, 0,0,0, 0,0, 0,0,0,0), O_RST, 8, 2);
      add(idle,                             O_P5,  0, 0);
      add(mkin(0,1,0, 0,0,0, 0,0, 1,0,1,0), O_P2,  0, 0);  // halt squashed by redirect
      add(idle,                             O_P5,  0, 1);
      add(mkin(0,1,0, 0,0,0, 0,0, 1,1,0,0), O_P1,  0, 1);  // halt held behind dmem
      add(idle,                             O_P5,  1, 1);
      add(mkin(0,1,0, 0,0,0, 0,0, 1,0,0,0), O_P5,  1, 1);
      add(mkin(1,1,0, 0,0,0, 0,0, 0,0,0,0), O_RST, 1, 1);  // reset mid-drain
      add(idle,                             O_P5,  0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge CLK);
         apply(tbl[i].in);
         #1;
         chk($sformatf("vec%0d", i), tbl[i].o, tbl[i].st, tbl[i].fl);
         model_step();
      end

      // Saturation: 20 load-use stalls on the 4-bit counter instance
      @(negedge CLK);
      apply(mkin(1,1,0, 0,0,0, 0,0, 0,0,0,0));
      #1; model_step();
      for (int i = 0; i <= 20; i++) begin
         @(negedge CLK);
         apply(i < 20 ? lu5 : idle);
         #1;
         total++;
         if (stall_cnt4 !== 4'(i > 15 ? 15 : i)) begin
            bad++;
            $display("FAIL sat%0d stall_cnt4: got %0d want %0d", i, stall_cnt4, (i > 15 ? 15 : i));
         end
         chk($sformatf("sat%0d", i), (i < 20 ? O_P3 : O_P5), i, 0);
         model_step();
      end

      // Random stimulus against the model
      for (int i = 0; i < 3000; i++) begin
         vin_t v;
         @(negedge CLK);
         v = mkin($urandom_range(0,63) == 0, $urandom_range(0,3) != 0, 1'($urandom),
                  5'($urandom_range(0,3)), 5'($urandom_range(0,3)), 1'($urandom),
                  1'($urandom), 5'($urandom_range(0,3)), $urandom_range(0,15) == 0,
                  1'($urandom), $urandom_range(0,3) == 0, $urandom_range(0,3) == 0);
         apply(v);
         #1;
         chk($sformatf("rnd%0d", i), model_outs(cur, m_state), m_st, m_fl);
         total++;
         if (stall_cnt4 !== 4'(m_st4)) begin
            bad++;
            $display("FAIL rnd%0d stall_cnt4: got %0d want %0d", i, stall_cnt4, m_st4);
         end
         model_step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
